hadamard_sched: RTL and testbench

HADAMARD_SCHED -- requirements
Module: hadamard_sched

---
 rtl/hadamard_sched_pkg.sv | 20 ++
 rtl/hadamard_rr_arb.sv | 44 ++++
 rtl/hadamard_sched.sv | 191 +++++++++++++++++++
 tb/tb_hadamard_sched.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hadamard_sched_pkg.sv
// Shared types and defaults for the Hadamard transform scheduler: FSM state
// encoding, default widths/latency and the requester id type.
package hadamard_sched_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_OUT_W    = 10;
    localparam int DEF_CORE_LAT = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } sched_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/hadamard_rr_arb.sv
// Two-requester round-robin arbiter. ptr_q names the requester that wins the
// next contested cycle; it flips to the other requester after every grant.
module hadamard_rr_arb
    import hadamard_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req_valid,
    output logic [1:0] grant,
    output req_id_t    grant_id
);

    req_id_t ptr_q;
    req_id_t ptr_d;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req_valid == 2'b11) begin
                grant = (ptr_q == REQ0) ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
        grant_id = grant[1] ? REQ1 : REQ0;

        ptr_d = ptr_q;
        if (grant[0]) begin
            ptr_d = REQ1;
        end else if (grant[1]) begin
            ptr_d = REQ0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hadamard_sched.sv
// Two-port operand scheduler in front of a fixed-latency 4-point Hadamard core,
// with halt/drain control. Optional per-requester result counters are enabled
// by the HADAMARD_SCHED_PERF_EN macro.
module hadamard_sched
    import hadamard_sched_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int CORE_LAT = DEF_CORE_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic [4*DATA_W-1:0] req0_x,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [4*DATA_W-1:0] req1_x,
    output logic                req1_ready,
    input  logic                halt,
    output logic                halt_ack,
    output logic                core_start,
    output logic [4*DATA_W-1:0] core_x,
    input  logic [4*OUT_W-1:0]  core_y,
    output logic                out_valid,
    output logic                out_id,
    output logic [4*OUT_W-1:0]  out_y
`ifdef HADAMARD_SCHED_PERF_EN
    ,
    output logic [15:0]         perf_cnt0,
    output logic [15:0]         perf_cnt1
`endif
);

    sched_state_e        state_q;
    sched_state_e        state_d;

    logic                arb_en;
    logic [1:0]          grant;
    req_id_t             grant_id;
    logic                accept;

    logic                core_start_q;
    logic                core_start_d;
    logic [4*DATA_W-1:0] core_x_q;
    logic [4*DATA_W-1:0] core_x_d;
    req_id_t             core_id_q;
    req_id_t             core_id_d;

    logic [CORE_LAT:0]   vld_p_q;
    logic [CORE_LAT:0]   vld_p_d;
    logic [CORE_LAT:0]   id_p_q;
    logic [CORE_LAT:0]   id_p_d;
    logic                pipe_empty;

    logic                out_valid_q;
    logic                out_valid_d;
    req_id_t             out_id_q;
    req_id_t             out_id_d;
    logic [4*OUT_W-1:0]  out_y_q;
    logic [4*OUT_W-1:0]  out_y_d;

    // Accepts only while running and not being asked to halt this cycle.
    assign arb_en = (state_q == RUN) && !halt;

    hadamard_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (arb_en),
        .req_valid ({req1_valid, req0_valid}),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    assign accept     = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        core_start_d = accept;
        core_id_d    = accept ? grant_id : core_id_q;
        core_x_d     = core_x_q;
        if (accept) begin
            core_x_d = (grant_id == REQ1) ? req1_x : req0_x;
        end

        // Tag stage CORE_LAT lines up with the cycle core_y is valid.
        vld_p_d[0] = core_start_q;
        id_p_d[0]  = core_id_q;
        for (int i = 1; i <= CORE_LAT; i++) begin
            vld_p_d[i] = vld_p_q[i-1];
            id_p_d[i]  = id_p_q[i-1];
        end

        out_valid_d = vld_p_q[CORE_LAT];
        out_id_d    = vld_p_q[CORE_LAT] ? id_p_q[CORE_LAT] : out_id_q;
        out_y_d     = vld_p_q[CORE_LAT] ? core_y : out_y_q;

        pipe_empty = !core_start_q && !(|vld_p_q);

        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!halt) begin
                    state_d = RUN;
                end else if (pipe_empty) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!halt) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            core_start_q <= 1'b0;
            core_x_q     <= '0;
            core_id_q    <= REQ0;
            vld_p_q      <= '0;
            id_p_q       <= '0;
            out_valid_q  <= 1'b0;
            out_id_q     <= REQ0;
            out_y_q      <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            core_x_q     <= core_x_d;
            core_id_q    <= core_id_d;
            vld_p_q      <= vld_p_d;
            id_p_q       <= id_p_d;
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_y_q      <= out_y_d;
        end
    end

    assign halt_ack   = (state_q == HALTED);
    assign core_start = core_start_q;
    assign core_x     = core_x_q;
    assign out_valid  = out_valid_q;
    assign out_id     = out_id_q;
    assign out_y      = out_y_q;

`ifdef HADAMARD_SCHED_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    logic [15:0] perf_cnt0_q;
    logic [15:0] perf_cnt0_d;
    logic [15:0] perf_cnt1_q;
    logic [15:0] perf_cnt1_d;

    // Counted on the same edge that raises out_valid, so the count is current
    // while the strobe is visible.
    always_comb begin
        perf_cnt0_d = perf_cnt0_q;
        perf_cnt1_d = perf_cnt1_q;
        if (out_valid_d && (out_id_d == REQ0)) begin
            perf_cnt0_d = sat_inc16(perf_cnt0_q);
        end
        if (out_valid_d && (out_id_d == REQ1)) begin
            perf_cnt1_d = sat_inc16(perf_cnt1_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt0_q <= '0;
            perf_cnt1_q <= '0;
        end else begin
            perf_cnt0_q <= perf_cnt0_d;
            perf_cnt1_q <= perf_cnt1_d;
        end
    end

    assign perf_cnt0 = perf_cnt0_q;
    assign perf_cnt1 = perf_cnt1_q;
`endif

endmodule

// File: tb/tb_hadamard_sched.sv
// Bench for hadamard_sched: a behavioural 4-point Hadamard core of latency 2
// plus a transaction-level reference model (arbitration, halt history, queue
// of expected results with due cycles).
module tb_hadamard_sched;

    localparam int DATA_W   = 8;
    localparam int OUT_W    = 10;
    localparam int CORE_LAT = 2;
    localparam int XW       = 4 * DATA_W;
    localparam int YW       = 4 * OUT_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [XW-1:0] req0_x, req1_x;
    logic          req0_ready, req1_ready;
    logic          halt;
    logic          halt_ack;
    logic          core_start;
    logic [XW-1:0] core_x;
    logic [YW-1:0] core_y;
    logic          out_valid;
    logic          out_id;
    logic [YW-1:0] out_y;
`ifdef HADAMARD_SCHED_PERF_EN
    logic [15:0]   perf_cnt0, perf_cnt1;
`endif

    hadamard_sched #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CORE_LAT(CORE_LAT)) dut (
        .clk        (clk),
`ifdef HADAMARD_SCHED_PERF_EN
        .perf_cnt0  (perf_cnt0),
        .perf_cnt1  (perf_cnt1),
`endif
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_x     (req0_x),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_x     (req1_x),
        .req1_ready (req1_ready),
        .halt       (halt),
        .halt_ack   (halt_ack),
        .core_start (core_start),
        .core_x     (core_x),
        .core_y     (core_y),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .out_y      (out_y)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [YW-1:0] h4(input logic [XW-1:0] x);
        int a[4];
        int y[4];
        logic [YW-1:0] r;
        for (int i = 0; i < 4; i++) a[i] = int'($signed(x[i*DATA_W +: DATA_W]));
        y[0] = a[0] + a[1] + a[2] + a[3];
        y[1] = a[0] - a[1] + a[2] - a[3];
        y[2] = a[0] + a[1] - a[2] - a[3];
        y[3] = a[0] - a[1] - a[2] + a[3];
        for (int i = 0; i < 4; i++) r[i*OUT_W +: OUT_W] = OUT_W'(y[i]);
        return r;
    endfunction

    function automatic logic [XW-1:0] pack4(input int e3, input int e2, input int e1, input int e0);
        return {DATA_W'(e3), DATA_W'(e2), DATA_W'(e1), DATA_W'(e0)};
    endfunction

    // Core model: samples core_x with core_start, result valid CORE_LAT cycles later.
    logic [XW-1:0] cm_in;
    logic [YW-1:0] cm_mid;
    always @(posedge clk) begin
        cm_in  <= core_x;
        cm_mid <= h4(cm_in);
        core_y <= cm_mid;
    end

    typedef struct {
        int            due;
        logic          id;
        logic [YW-1:0] y;
    } sb_t;

    sb_t           sb[$];
    logic          m_prio, m_last_halt, m_halted, m_cs, m_id;
    logic [XW-1:0] m_cx;
    logic [YW-1:0] m_y;
    int            m_pc0, m_pc1;

    logic          exp_rdy0, exp_rdy1, exp_ov, exp_id, exp_ack, exp_cs;
    logic [YW-1:0] exp_y;
    logic [XW-1:0] exp_cx;

    task automatic model_reset();
        sb.delete();
        m_prio = 0; m_last_halt = 0; m_halted = 0; m_cs = 0; m_id = 0;
        m_cx = '0; m_y = '0; m_pc0 = 0; m_pc1 = 0;
    endtask

    task automatic set_in(input logic v0, input logic [XW-1:0] x0,
                          input logic v1, input logic [XW-1:0] x1, input logic h);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_x = x0; req1_valid = v1; req1_x = x1; halt = h;
    endtask

    // Advance to the negedge, publish expected outputs for this cycle, then
    // account for the handshake at the coming edge.
    task automatic cycle();
        logic en, g0, g1, empty;
        sb_t e;
        @(negedge clk);
        en = !m_last_halt && !halt;
        g0 = en && req0_valid && (!req1_valid || !m_prio);
        g1 = en && req1_valid && !g0;
        exp_rdy0 = g0;
        exp_rdy1 = g1;
        exp_ov = 0;
        if (sb.size() > 0) begin
            if (sb[0].due == cyc) exp_ov = 1;
        end
        if (exp_ov) begin
            m_id = sb[0].id;
            m_y  = sb[0].y;
            if (sb[0].id) m_pc1 = (m_pc1 < 65535) ? m_pc1 + 1 : m_pc1;
            else          m_pc0 = (m_pc0 < 65535) ? m_pc0 + 1 : m_pc0;
            void'(sb.pop_front());
        end
        exp_id  = m_id;
        exp_y   = m_y;
        exp_ack = m_halted;
        exp_cs  = m_cs;
        exp_cx  = m_cx;
        empty = (sb.size() == 0);
        m_halted    = halt && m_last_halt && (m_halted || empty);
        m_last_halt = halt;
        m_cs = g0 || g1;
        if (g0 || g1) begin
            m_cx   = g0 ? req0_x : req1_x;
            e.due  = cyc + 1 + CORE_LAT + 2;
            e.id   = g1;
            e.y    = h4(m_cx);
            sb.push_back(e);
            m_prio = g0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 0; req0_valid = 0; req1_valid = 0; halt = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_id, out_y, core_start, core_x, halt_ack} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ov=%b id=%b y=%h cs=%b cx=%h ack=%b want all zero",
                     out_valid, out_id, out_y, core_start, core_x, halt_ack);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        req0_valid = 1; req0_x = $urandom();
        cycle();
        checks++;
        if (req0_ready !== 1'b1 || exp_rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL first_accept got ready=%b want 1", req0_ready);
        end
        for (int k = 0; k < 7; k++) begin
            set_in(0, '0, 0, '0, 0);
            cycle();
            checks++;
            if ({req0_ready, req1_ready, out_valid, halt_ack, core_start, out_id, out_y, core_x} !==
                {exp_rdy0, exp_rdy1, exp_ov, exp_ack, exp_cs, exp_id, exp_y, exp_cx}) begin
                errors++;
                $display("FAIL first_result cyc=%0d got ov=%b cs=%b y=%h want ov=%b cs=%b y=%h",
                         cyc, out_valid, core_start, out_y, exp_ov, exp_cs, exp_y);
            end
        end
    endtask

    task automatic test_basic();
        int acc_cyc;
        int seen = 0;
        logic [YW-1:0] want;
        want = {10'sd2, 10'sd8, -10'sd4, 10'sd6};
        set_in(1, pack4(1, -2, 4, 3), 0, '0, 0);
        cycle();
        acc_cyc = cyc + 1;
        for (int k = 0; k < 7; k++) begin
            set_in(0, '0, 0, '0, 0);
            cycle();
            checks++;
            if ({out_valid, core_start, out_id, out_y, core_x} !== {exp_ov, exp_cs, exp_id, exp_y, exp_cx}) begin
                errors++;
                $display("FAIL basic_cycle cyc=%0d got ov=%b y=%h want ov=%b y=%h", cyc, out_valid, out_y, exp_ov, exp_y);
            end
            if (out_valid === 1'b1) begin
                seen++;
                checks++;
                if (out_y !== want || out_id !== 1'b0 || (cyc - acc_cyc) != 4) begin
                    errors++;
                    $display("FAIL basic_result got y=%h id=%b lat=%0d want y=%h id=0 lat=4",
                             out_y, out_id, cyc - acc_cyc, want);
                end
            end
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL basic_count got %0d want 1", seen);
        end
    endtask

    task automatic test_round_robin();
        int ids[$];
        int cycs[$];
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k < 6) set_in(1, pack4($urandom_range(255), $urandom_range(255), -3, 5), 1,
                              pack4($urandom_range(255), $urandom_range(255), 6, -1), 0);
            else       set_in(0, '0, 0, '0, 0);
            cycle();
            checks++;
            if ({req0_ready, req1_ready, out_valid, core_start, out_id, out_y, core_x} !==
                {exp_rdy0, exp_rdy1, exp_ov, exp_cs, exp_id, exp_y, exp_cx}) begin
                errors++;
                $display("FAIL rr_cycle cyc=%0d got rdy=%b%b ov=%b id=%b want rdy=%b%b ov=%b id=%b",
                         cyc, req0_ready, req1_ready, out_valid, out_id, exp_rdy0, exp_rdy1, exp_ov, exp_id);
            end
            if (out_valid === 1'b1) begin
                ids.push_back(int'(out_id));
                cycs.push_back(cyc);
            end
        end
        checks++;
        if (ids.size() != 6) begin
            errors++;
            $display("FAIL rr_count got %0d want 6", ids.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (ids[i] != (i % 2) || cycs[i] != cycs[0] + i) begin
                    errors++;
                    $display("FAIL rr_order idx=%0d got id=%0d at +%0d want id=%0d at +%0d",
                             i, ids[i], cycs[i] - cycs[0], i % 2, i);
                end
            end
        end
    endtask

    task automatic test_halt();
        int n_out = 0;
        int last_out = -1;
        int ack_cyc = -1;
        for (int k = 0; k < 3; k++) begin
            set_in(1, $urandom(), 1'($urandom_range(1)), $urandom(), 0);
            cycle();
        end
        for (int k = 0; k < 12; k++) begin
            set_in(1'($urandom_range(1)), $urandom(), 1'($urandom_range(1)), $urandom(), 1);
            cycle();
            checks++;
            if ({req0_ready, req1_ready, out_valid, halt_ack, out_id, out_y} !==
                {2'b00, exp_ov, exp_ack, exp_id, exp_y}) begin
                errors++;
                $display("FAIL halt_cycle cyc=%0d got rdy=%b%b ov=%b ack=%b want rdy=00 ov=%b ack=%b",
                         cyc, req0_ready, req1_ready, out_valid, halt_ack, exp_ov, exp_ack);
            end
            if (out_valid === 1'b1) begin
                n_out++;
                last_out = cyc;
            end
            if (halt_ack === 1'b1 && ack_cyc < 0) ack_cyc = cyc;
        end
        checks++;
        if (n_out != 3 || ack_cyc != last_out + 1) begin
            errors++;
            $display("FAIL halt_drain got results=%0d ack_at=%0d want results=3 ack_at=%0d",
                     n_out, ack_cyc, last_out + 1);
        end
        for (int k = 0; k < 9; k++) begin
            set_in(k < 2, $urandom(), 0, '0, 0);
            cycle();
            checks++;
            if ({req0_ready, req1_ready, out_valid, halt_ack, core_start, out_id, out_y, core_x} !==
                {exp_rdy0, exp_rdy1, exp_ov, exp_ack, exp_cs, exp_id, exp_y, exp_cx}) begin
                errors++;
                $display("FAIL resume_cycle cyc=%0d got rdy=%b ov=%b ack=%b want rdy=%b ov=%b ack=%b",
                         cyc, req0_ready, out_valid, halt_ack, exp_rdy0, exp_ov, exp_ack);
            end
            if (k < 2) begin
                checks++;
                if (req0_ready !== logic'(k == 1)) begin
                    errors++;
                    $display("FAIL resume_ready k=%0d got %b want %b", k, req0_ready, k == 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        set_in(1, pack4(-5, -1, -3, -2), 0, '0, 0);
        cycle();
        set_in(0, '0, 0, '0, 0);
        cycle();
        @(posedge clk);
        #1;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, out_id, out_y, core_start, core_x, halt_ack, req0_ready, req1_ready} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got ov=%b id=%b y=%h cs=%b cx=%h want all zero",
                     out_valid, out_id, out_y, core_start, core_x);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int k = 0; k < 8; k++) begin
            set_in(0, '0, 0, '0, 0);
            cycle();
            checks++;
            if (out_valid !== 1'b0 || out_y !== '0 || exp_ov !== 1'b0) begin
                errors++;
                $display("FAIL midreset_discard cyc=%0d got ov=%b y=%h want ov=0 y=0", cyc, out_valid, out_y);
            end
        end
    endtask

    task automatic test_extremes();
        logic [OUT_W-1:0] want0[2];
        int idx = 0;
        want0[0] = OUT_W'(508);
        want0[1] = OUT_W'(-512);
        for (int k = 0; k < 9; k++) begin
            if (k == 0)      set_in(1, pack4(127, 127, 127, 127), 0, '0, 0);
            else if (k == 1) set_in(0, '0, 1, pack4(-128, -128, -128, -128), 0);
            else             set_in(0, '0, 0, '0, 0);
            cycle();
            checks++;
            if ({out_valid, out_id, out_y} !== {exp_ov, exp_id, exp_y}) begin
                errors++;
                $display("FAIL extreme_cycle cyc=%0d got ov=%b y=%h want ov=%b y=%h", cyc, out_valid, out_y, exp_ov, exp_y);
            end
            if (out_valid === 1'b1 && idx < 2) begin
                checks++;
                if (out_y[OUT_W-1:0] !== want0[idx] || out_y[YW-1:OUT_W] !== '0) begin
                    errors++;
                    $display("FAIL extreme_y0 idx=%0d got y=%h want y0=%h others 0", idx, out_y, want0[idx]);
                end
                idx++;
            end
        end
        checks++;
        if (idx != 2) begin
            errors++;
            $display("FAIL extreme_count got %0d want 2", idx);
        end
    endtask

    task automatic test_random();
        int hcnt = 0;
        logic h;
        for (int k = 0; k < 80; k++) begin
            h = 0;
            if (k < 70) begin
                if (hcnt > 0) begin
                    h = 1;
                    hcnt--;
                end else if ($urandom_range(7) == 0) begin
                    hcnt = $urandom_range(6, 1);
                end
                set_in(1'($urandom_range(1)), $urandom(), 1'($urandom_range(1)), $urandom(), h);
            end else begin
                set_in(0, '0, 0, '0, 0);
            end
            cycle();
            checks++;
            if ({req0_ready, req1_ready, out_valid, halt_ack, core_start, out_id, out_y, core_x} !==
                {exp_rdy0, exp_rdy1, exp_ov, exp_ack, exp_cs, exp_id, exp_y, exp_cx}) begin
                errors++;
                $display("FAIL random_cycle cyc=%0d got rdy=%b%b ov=%b ack=%b id=%b y=%h want rdy=%b%b ov=%b ack=%b id=%b y=%h",
                         cyc, req0_ready, req1_ready, out_valid, halt_ack, out_id, out_y,
                         exp_rdy0, exp_rdy1, exp_ov, exp_ack, exp_id, exp_y);
            end
        end
    endtask

`ifdef HADAMARD_SCHED_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k < 5)      set_in(1, $urandom(), 0, '0, 0);
            else if (k < 8) set_in(0, '0, 1, $urandom(), 0);
            else            set_in(0, '0, 0, '0, 0);
            cycle();
            checks++;
            if (perf_cnt0 !== 16'(m_pc0) || perf_cnt1 !== 16'(m_pc1)) begin
                errors++;
                $display("FAIL perf_track cyc=%0d got %0d/%0d want %0d/%0d", cyc, perf_cnt0, perf_cnt1, m_pc0, m_pc1);
            end
        end
        checks++;
        if (perf_cnt0 !== 16'd5 || perf_cnt1 !== 16'd3) begin
            errors++;
            $display("FAIL perf_final got %0d/%0d want 5/3", perf_cnt0, perf_cnt1);
        end
    endtask
`endif

    initial begin
        rst_n = 0; req0_valid = 0; req1_valid = 0; req0_x = '0; req1_x = '0; halt = 0;
        model_reset();
        test_reset();
        test_basic();
        test_round_robin();
        test_halt();
        test_reset_mid();
        test_extremes();
        test_random();
`ifdef HADAMARD_SCHED_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
